// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch front end: the bubble encoding,
// the redirect target selectors and the fetch queue entry layout.
package fetch_stage_pkg;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCTYPE_BRANCH = 2'b00,
    PCTYPE_REG    = 2'b01,
    PCTYPE_JUMP   = 2'b10,
    PCTYPE_SEQ    = 2'b11
  } pctype_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bus bundle: instruction memory port, Fetch->Decode register
// outputs and Decode->Fetch redirect/stall controls.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic [31:0] if_id_instruc;
  logic [31:0] if_id_nextpc;
  logic        if_id_valid;

  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcindex;
  logic        id_stall;

  modport master (
    output imem_req, imem_addr, if_id_instruc, if_id_nextpc, if_id_valid,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext,
    input  id_if_rega, id_if_pcindex, id_stall
  );

  modport slave (
    input  imem_req, imem_addr, if_id_instruc, if_id_nextpc, if_id_valid,
    output imem_gnt, imem_rvalid, imem_rdata,
    output id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext,
    output id_if_rega, id_if_pcindex, id_stall
  );

endinterface

// File: rtl/fetch_stage_queue.sv
// fetch_queue: small synchronous FIFO holding {instr, pc} responses while
// Decode is stalled. Flush wins over push; DEPTH must be a power of 2.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush & (count != CNT_W'(DEPTH));
  assign do_pop  = pop & ~flush & (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, in-order imem requests, response queue and the
// Fetch->Decode register. Define FETCH_PERF_EN to add redirect/bubble counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                clock,
  input  logic                reset,
  fetch_stage_if.master       bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_redirects,
  output logic [31:0]         perf_bubbles
`endif
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic [31:0]      pc;
  logic [31:0]      rsp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   occupancy;
  fetch_entry_t     q_head;
  logic [31:0]      target_raw;
  logic [31:0]      target;
  logic             redirect;
  logic             fire;
  logic             accept;
  logic             q_empty;
  logic             bypass;

  assign redirect  = bus.id_if_selpcsource & bus.if_id_valid & ~bus.id_stall;
  assign occupancy = {1'b0, outstanding} + {1'b0, q_count};
  assign bus.imem_req  = reset & ~redirect & (occupancy < (CNT_W + 1)'(QDEPTH));
  assign bus.imem_addr = pc;
  assign fire      = bus.imem_req & bus.imem_gnt;
  // Stale responses are counted off by drop_cnt; a redirect discards the current one too.
  assign accept    = bus.imem_rvalid & (drop_cnt == '0) & ~redirect;
  assign q_empty   = (q_count == '0);
  assign bypass    = accept & q_empty & ~bus.id_stall;

  // NOTE: default first so every path assigns target_raw and no latch is inferred.
  always_comb begin
    target_raw = bus.id_if_pcimd2ext;
    case (pctype_e'(bus.id_if_selpctype))
      PCTYPE_BRANCH: target_raw = bus.id_if_pcimd2ext;
      PCTYPE_REG:    target_raw = bus.id_if_rega;
      PCTYPE_JUMP:   target_raw = bus.id_if_pcindex;
      PCTYPE_SEQ:    target_raw = bus.if_id_nextpc;
      default:       target_raw = bus.id_if_pcimd2ext;
    endcase
  end

  assign target = word_align(target_raw);

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (accept & ~bypass),
    .pop       (~bus.id_stall & ~redirect),
    .flush     (redirect),
    .push_data ('{instr: bus.imem_rdata, pc: rsp_pc}),
    .head      (q_head),
    .count     (q_count)
  );

  // NOTE: non-blocking assignments keep every register update on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      pc          <= target;
      rsp_pc      <= target;
      outstanding <= outstanding - CNT_W'(bus.imem_rvalid);
      drop_cnt    <= outstanding - CNT_W'(bus.imem_rvalid);
    end else begin
      if (fire) pc <= pc + 32'd4;
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(bus.imem_rvalid);
      if (bus.imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      if (accept) rsp_pc <= rsp_pc + 32'd4;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.if_id_instruc <= FETCH_NOP;
      bus.if_id_nextpc  <= '0;
      bus.if_id_valid   <= 1'b0;
    end else if (!bus.id_stall) begin
      if (!redirect && !q_empty) begin
        bus.if_id_instruc <= q_head.instr;
        bus.if_id_nextpc  <= q_head.pc + 32'd4;
        bus.if_id_valid   <= 1'b1;
      end else if (bypass) begin
        bus.if_id_instruc <= bus.imem_rdata;
        bus.if_id_nextpc  <= rsp_pc + 32'd4;
        bus.if_id_valid   <= 1'b1;
      end else begin
        bus.if_id_instruc <= FETCH_NOP;
        bus.if_id_valid   <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble_load;
  assign bubble_load = ~bus.id_stall & ~redirect & q_empty & ~accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_redirects <= '0;
      perf_bubbles   <= '0;
    end else begin
      if (redirect)    perf_redirects <= perf_redirects + 32'd1;
      if (bubble_load) perf_bubbles   <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed streaming/stall/redirect
// scenarios plus a randomized run against a program-order reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_stage_if bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_bubbles;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents are a fixed scramble of the address, so any wrong fetch shows.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] pick_target();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(15));
    return $urandom;
  endfunction

  typedef struct { logic [31:0] addr; int ready; } mem_req_t;
  mem_req_t mem_q[$];

  int gnt_pct, stall_pct, redir_pct, lat_lo, lat_hi;
  bit force_stall, force_armed;
  logic [31:0] force_at, force_val;
  logic [1:0]  force_type;

  // Reference model: the next PC Decode should see in program order.
  logic [31:0] exp_pc, last_np, prev_addr, prev_instr, prev_np, pend_addr;
  logic [31:0] model_redirects, model_bubbles;
  bit prev_stall, prev_redir, prev_req, prev_gnt, prev_valid, pend_tgt, redir_flag;
  int cyc, n_valid;

  task automatic clear_inputs();
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.id_if_selpcsource = 0; bus.id_if_selpctype = 0;
    bus.id_if_pcimd2ext = 0; bus.id_if_rega = 0; bus.id_if_pcindex = 0;
    bus.id_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    mem_q.delete();
    force_armed = 0; force_stall = 0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_req", 32'(bus.imem_req), 0);
    check("rst_valid", 32'(bus.if_id_valid), 0);
    check("rst_instr", bus.if_id_instruc, FETCH_NOP);
    check("rst_nextpc", bus.if_id_nextpc, 0);
`ifdef FETCH_PERF_EN
    check("rst_perf_redir", perf_redirects, 0);
    check("rst_perf_bubble", perf_bubbles, 0);
`endif
    exp_pc = 0; last_np = 0; pend_tgt = 0; redir_flag = 0;
    prev_stall = 0; prev_redir = 0; prev_req = 0; prev_gnt = 0;
    model_redirects = 0; model_bubbles = 0; cyc = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic step();
    bit redir;
    logic [31:0] tgt;
    @(negedge clock);
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      bus.imem_rvalid = 1; bus.imem_rdata = mem_word(mem_q[0].addr);
    end else begin
      bus.imem_rvalid = 0; bus.imem_rdata = $urandom;
    end
    bus.imem_gnt = ($urandom_range(99) < gnt_pct);
    bus.id_stall = force_stall || ($urandom_range(99) < stall_pct);
    bus.id_if_pcimd2ext = pick_target();
    bus.id_if_rega = pick_target();
    bus.id_if_pcindex = pick_target();
    bus.id_if_selpctype = 2'($urandom_range(3));
    bus.id_if_selpcsource = ($urandom_range(99) < redir_pct);
    if (force_armed) begin
      bus.id_if_selpcsource = 0;
      if (bus.if_id_valid && bus.if_id_nextpc == force_at && !bus.id_stall) begin
        bus.id_if_selpcsource = 1;
        bus.id_if_selpctype = force_type;
        case (force_type)
          2'b00: bus.id_if_pcimd2ext = force_val;
          2'b01: bus.id_if_rega = force_val;
          2'b10: bus.id_if_pcindex = force_val;
          default: ;
        endcase
        force_armed = 0;
      end
    end
    #1;
    // Decode-side register contents
    if (prev_stall) begin
      check("stall_valid", 32'(bus.if_id_valid), 32'(prev_valid));
      check("stall_instr", bus.if_id_instruc, prev_instr);
      check("stall_nextpc", bus.if_id_nextpc, prev_np);
    end else if (prev_redir) begin
      check("redir_bubble", 32'(bus.if_id_valid), 0);
      check("redir_nop", bus.if_id_instruc, FETCH_NOP);
      check("redir_nextpc", bus.if_id_nextpc, last_np);
    end else if (bus.if_id_valid) begin
      check("instr", bus.if_id_instruc, mem_word(exp_pc));
      check("nextpc", bus.if_id_nextpc, exp_pc + 32'd4);
      last_np = exp_pc + 32'd4;
      exp_pc = exp_pc + 32'd4;
      n_valid++;
    end else begin
      check("bubble_nop", bus.if_id_instruc, FETCH_NOP);
      check("bubble_nextpc", bus.if_id_nextpc, last_np);
      model_bubbles++;
    end
`ifdef FETCH_PERF_EN
    check("perf_redirects", perf_redirects, model_redirects);
    check("perf_bubbles", perf_bubbles, model_bubbles);
`endif
    redir = bus.id_if_selpcsource && bus.if_id_valid && !bus.id_stall;
    // Memory-side request behaviour
    if (bus.imem_req) check("addr_align", 32'(bus.imem_addr[1:0]), 0);
    if (prev_req && !prev_gnt && !redir) begin
      check("hold_req", 32'(bus.imem_req), 1);
      check("hold_addr", bus.imem_addr, prev_addr);
    end
    if (pend_tgt && bus.imem_req) begin
      check("target_addr", bus.imem_addr, pend_addr);
      pend_tgt = 0;
    end
    redir_flag = redir;
    if (redir) begin
      check("redir_noreq", 32'(bus.imem_req), 0);
      case (bus.id_if_selpctype)
        2'b00:   tgt = bus.id_if_pcimd2ext;
        2'b01:   tgt = bus.id_if_rega;
        2'b10:   tgt = bus.id_if_pcindex;
        default: tgt = last_np;
      endcase
      tgt[1:0] = 2'b00;
      exp_pc = tgt;
      pend_tgt = 1; pend_addr = tgt;
      model_redirects++;
    end
    if (bus.imem_rvalid) void'(mem_q.pop_front());
    if (bus.imem_req && bus.imem_gnt)
      mem_q.push_back('{addr: bus.imem_addr, ready: cyc + $urandom_range(lat_hi, lat_lo)});
    prev_stall = bus.id_stall; prev_redir = redir;
    prev_req = bus.imem_req; prev_gnt = bus.imem_gnt; prev_addr = bus.imem_addr;
    prev_valid = bus.if_id_valid; prev_instr = bus.if_id_instruc; prev_np = bus.if_id_nextpc;
    cyc++;
  endtask

  task automatic run_until_redirect(input logic [31:0] at, input logic [1:0] typ,
                                    input logic [31:0] val, input int budget);
    bit seen = 0;
    force_at = at; force_type = typ; force_val = val; force_armed = 1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = redir_flag;
    end
    if (!seen) check("redir_timeout", 0, 1);
    force_armed = 0;
  endtask

  task automatic expect_next_valid(input string tag, input logic [31:0] np, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus.if_id_valid) begin
        check(tag, bus.if_id_nextpc, np);
        seen = 1;
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    clear_inputs();
    gnt_pct = 100; stall_pct = 0; redir_pct = 0; lat_lo = 1; lat_hi = 1;

    // Streaming at one instruction per cycle
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step();
      check("stream_valid", 32'(bus.if_id_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) check("stream_nextpc", bus.if_id_nextpc, 32'(4 * (k - 1)));
    end

    // Three-cycle Decode stall: requests throttle, nothing lost
    force_stall = 1;
    step();
    step(); check("stall_req_drop1", 32'(bus.imem_req), 0);
    step(); check("stall_req_drop2", 32'(bus.imem_req), 0);
    force_stall = 0;
    repeat (10) step();

    // Taken branch with stale responses in flight
    lat_lo = 2; lat_hi = 2;
    do_reset();
    run_until_redirect(32'h14, 2'b00, 32'h100, 60);
    expect_next_valid("branch_nextpc", 32'h104, 20);

    // Register jump, redirect coinciding with a response
    lat_lo = 1; lat_hi = 1;
    do_reset();
    run_until_redirect(32'h10, 2'b01, 32'h203, 60);
    step();
    check("jr_req", 32'(bus.imem_req), 1);
    check("jr_addr", bus.imem_addr, 32'h200);
    expect_next_valid("jr_nextpc", 32'h204, 20);

    // Latency 3 with toggling grant
    lat_lo = 3; lat_hi = 3; gnt_pct = 50;
    do_reset();
    n_valid = 0;
    repeat (200) step();
    check("lat3_progress", 32'(n_valid > 20), 1);

    // Fully randomized run
    lat_lo = 1; lat_hi = 3; gnt_pct = 70; stall_pct = 25; redir_pct = 8;
    do_reset();
    n_valid = 0;
    repeat (3000) step();
    check("random_progress", 32'(n_valid > 200), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch front end of the pipeline; drives the Fetch->Decode interface (if_id_*) and consumes Decode's redirect signals (id_if_*).
- Holds the PC and issues in-order requests to instruction memory, with up to QDEPTH in flight.
- Buffers responses in a small queue so Decode stalls never lose instructions.
- On a taken redirect, drops in-flight wrong-path responses and presents one bubble in the slot Decode discards.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset
QDEPTH, 2, combined limit on outstanding requests plus queued responses (power of 2, >=2)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
imem_req  out  1  request valid
imem_addr  out  32  word-aligned fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in request order, latency >=1
imem_rdata  in  32  response instruction
if_id_instruc  out  32  instruction presented to Decode
if_id_nextpc  out  32  PC of that instruction + 4
if_id_valid  out  1  1 = real instruction, 0 = bubble
id_if_selpcsource  in  1  redirect request from Decode (combinational)
id_if_selpctype  in  2  target select: 00 pcimd2ext, 01 rega, 10 pcindex, 11 if_id_nextpc
id_if_pcimd2ext  in  32  branch target
id_if_rega  in  32  register target (jr)
id_if_pcindex  in  32  jump target
id_stall  in  1  Decode holding; if_id_* must stay stable

Behaviour:
- Reset (async, active-low):
  - pc=RESET_PC; rsp_pc=RESET_PC; outstanding=0; drop_cnt=0; queue empty.
  - imem_req=0; if_id_instruc=FETCH_NOP (32'h0000_0000); if_id_nextpc=0; if_id_valid=0.
  - Reset mid-operation discards everything; responses arriving after reset release while drop_cnt=0 are treated as valid, so memory must be reset together with this block.
- redirect = id_if_selpcsource & if_id_valid & ~id_stall.
- target is selected by id_if_selpctype, with bits [1:0] forced to 00.
- Request:
  - imem_req = ~redirect & (outstanding + qcount < QDEPTH); imem_addr = pc.
  - On imem_req & imem_gnt: pc <= pc+4; outstanding++.
  - With imem_gnt=0, imem_req and imem_addr stay stable until granted.
- Response (no redirect):
  - On imem_rvalid: outstanding--.
  - If drop_cnt>0, the response is dropped and drop_cnt decrements.
  - Otherwise it is pushed into the queue as {rdata, rsp_pc}, and rsp_pc += 4.
- If_id register, updated only when ~id_stall:
  - Queue non-empty: load the head, valid=1, nextpc=entry_pc+4.
  - Queue empty and a non-dropped response arrives: bypass it directly (zero-bubble path).
  - Otherwise load a bubble: FETCH_NOP, valid=0, nextpc unchanged.
  - When id_stall=1, all if_id_* outputs hold; responses keep filling the queue; the capacity rule guarantees no overflow.
- Redirect cycle:
  - No request is issued.
  - pc <= target; rsp_pc <= target; queue is flushed.
  - drop_cnt <= outstanding - imem_rvalid; any response arriving in the same cycle is discarded.
  - If_id loads a bubble; this is the slot Decode discards. The first target instruction appears no earlier than 2 cycles after the redirect.
- The redirect is sampled only while if_id_valid=1; redirects during bubbles are ignored.
- Throughput: 1 instruction/cycle at latency 1 with gnt=1.
- Arithmetic: all PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_redirects[31:0] and perf_bubbles[31:0].
  - perf_redirects counts cycles with redirect=1.
  - perf_bubbles counts bubble loads while ~id_stall, excluding the bubble loaded by a redirect.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FETCH_NOP.
  - PCTYPE_BRANCH=2'b00, PCTYPE_REG=2'b01, PCTYPE_JUMP=2'b10, PCTYPE_SEQ=2'b11.
  - Fetch queue entry typedef {instr[31:0], pc[31:0]}.
- Sub-module fetch_queue: synchronous FIFO, QDEPTH entries, with push, pop, flush, count, head. Flush has priority over push.

Test Plan:
- Reset then gnt=1, latency 1, id_stall=0 -> addresses 0,4,8,...; if_id_nextpc 4,8,12,... on consecutive cycles after the first fill; valid=1.
- id_stall=1 for 3 cycles mid-stream -> if_id_* frozen; imem_req drops once outstanding+qcount=2; after release, no instruction lost or duplicated.
- Taken branch at nextpc=0x14 with pcimd2ext=0x100 and 2 requests outstanding -> both stale responses dropped; one bubble (valid=0); next valid if_id_nextpc=0x104.
- selpctype=01 with rega=0x203 -> fetch address 0x200.
- Redirect in the same cycle as imem_rvalid with outstanding=1 -> response dropped; drop_cnt=0; target fetched next cycle.
- Latency 3 with gnt toggling -> imem_addr held while gnt=0; instruction order preserved; bubbles inserted, counted by perf_bubbles when FETCH_PERF_EN is defined.
